wm_phase_timer: RTL and testbench

Countdown scheduler for the washing-machine phase controller. It tracks the controller's `state` code, loads the prep, wash or dry duration on each phase entry and counts it down in BCD hours and minutes. It freezes during pauses and issues the one-cycle `complete_op` pulse that the controller uses to advance. It sits between the time-setting/keypad logic and the phase FSM, and it also drives the remaining-time display digits.

---
 rtl/wm_pkg.sv | 24 ++
 rtl/wm_phase_timer_if.sv | 29 ++
 rtl/wm_phase_timer_bcd.sv | 56 +++++
 rtl/wm_phase_timer.sv | 164 ++++++++++++++++
 tb/tb_wm_phase_timer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine phase timer: phase codes,
// BCD digit limits and the hours/minutes payload carried between blocks.
package wm_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] MIN_TEN_MAX = BCD_W'(5);
  localparam logic [BCD_W-1:0] DIGIT_MAX   = BCD_W'(9);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WASH   = 3'd1,
    ST_WASH_P = 3'd2,
    ST_DRY    = 3'd3,
    ST_DRY_P  = 3'd4,
    ST_PREP   = 3'd5
  } phase_e;

  typedef struct packed {
    logic [BCD_W-1:0] hr;
    logic [BCD_W-1:0] min_ten;
    logic [BCD_W-1:0] min_one;
  } bcd_hm_t;

endpackage

// File: rtl/wm_phase_timer_if.sv
// Bundle between the phase controller / keypad side and the phase timer.
//   state            : controller phase code
//   wash_*, dry_*    : programmed durations, BCD h:mm
//   rem_*            : remaining time, BCD h:mm
//   complete_op      : one-cycle pulse when the phase count expires
//   running          : phase actively counting
interface wm_phase_timer_if;
  import wm_pkg::*;

  logic [2:0]       state;
  logic [BCD_W-1:0] wash_hr, wash_min_ten, wash_min_one;
  logic [BCD_W-1:0] dry_hr, dry_min_ten, dry_min_one;
  logic [BCD_W-1:0] rem_hr, rem_min_ten, rem_min_one;
  logic             complete_op;
  logic             running;

  modport master (
    output state, wash_hr, wash_min_ten, wash_min_one,
           dry_hr, dry_min_ten, dry_min_one,
    input  rem_hr, rem_min_ten, rem_min_one, complete_op, running
  );

  modport slave (
    input  state, wash_hr, wash_min_ten, wash_min_one,
           dry_hr, dry_min_ten, dry_min_one,
    output rem_hr, rem_min_ten, rem_min_one, complete_op, running
  );

endinterface

// File: rtl/wm_phase_timer_bcd.sv
// BCD h:mm down counter with load-time clamping.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (clamped to a legal BCD time)
//   load_val   : value to load
//   dec        : decrement one minute; holds at 0:00
//   cnt        : registered count
//   zero       : count is 0:00
module bcd_hm_down_counter
  import wm_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    load,
  input  bcd_hm_t load_val,
  input  logic    dec,
  output bcd_hm_t cnt,
  output logic    zero
);

  bcd_hm_t cnt_n;

  function automatic logic [BCD_W-1:0] clamp(input logic [BCD_W-1:0] d,
                                             input logic [BCD_W-1:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  assign zero = (cnt == '0);

  // Next count: clamped load, or minute decrement with borrow chain
  always_comb begin
    cnt_n = cnt;
    if (load) begin
      cnt_n.hr      = clamp(load_val.hr, DIGIT_MAX);
      cnt_n.min_ten = clamp(load_val.min_ten, MIN_TEN_MAX);
      cnt_n.min_one = clamp(load_val.min_one, DIGIT_MAX);
    end else if (dec && !zero) begin
      if (cnt.min_one != '0) begin
        cnt_n.min_one = cnt.min_one - BCD_W'(1);
      end else begin
        cnt_n.min_one = DIGIT_MAX;
        if (cnt.min_ten != '0) begin
          cnt_n.min_ten = cnt.min_ten - BCD_W'(1);
        end else begin
          cnt_n.min_ten = MIN_TEN_MAX;
          cnt_n.hr      = cnt.hr - BCD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_n;
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase countdown scheduler: loads prep/wash/dry durations on phase entry,
// counts down one minute per TICK_DIV cycles, freezes in pauses and pulses
// complete_op once when the phase count expires.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of wm_phase_timer_if (state, durations in;
//                remaining time, complete_op, running out)
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned PREP_TICKS = 3
)(
  input logic             clk,
  input logic             reset,
  wm_phase_timer_if.slave bus
);

  localparam int unsigned   PS_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned   PR_W      = (PREP_TICKS > 0) ? $clog2(PREP_TICKS + 1) : 1;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICK_DIV - 1);
  localparam logic [PR_W-1:0] PREP_LOAD = PR_W'(PREP_TICKS);
  localparam logic            PREP_ZERO = (PREP_TICKS == 0);

  logic [2:0]      st, prev_q, prev_n;
  logic [PS_W-1:0] ps_q, ps_n;
  logic [PR_W-1:0] prep_q, prep_n;
  logic            done_q, done_n, co_q, co_n, run_q, run_n;
  logic            entry, active, tick, do_load, do_clear, load_zero;
  logic            cnt_load, cnt_dec, cnt_zero, cnt_is_one;
  bcd_hm_t         cnt_val, cnt_q, wash_t, dry_t;

  assign st     = bus.state;
  assign wash_t = {bus.wash_hr, bus.wash_min_ten, bus.wash_min_one};
  assign dry_t  = {bus.dry_hr, bus.dry_min_ten, bus.dry_min_one};

  assign cnt_is_one = (cnt_q.hr == '0) && (cnt_q.min_ten == '0) &&
                      (cnt_q.min_one == BCD_W'(1));

  bcd_hm_down_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt_q),
    .zero     (cnt_zero)
  );

  // Entry decode, prescaler, prep counter and expiry
  always_comb begin
    prev_n    = st;
    ps_n      = ps_q;
    prep_n    = prep_q;
    done_n    = done_q;
    co_n      = 1'b0;
    run_n     = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    tick      = 1'b0;
    do_load   = 1'b0;
    do_clear  = 1'b0;
    load_zero = 1'b0;
    entry     = (st != prev_q);
    active    = (st == ST_WASH) || (st == ST_DRY) || (st == ST_PREP);

    if (st == ST_IDLE) begin
      do_clear = 1'b1;
    end else if (entry && active) begin
      if (st == ST_PREP && prev_q == ST_IDLE) begin
        do_load   = 1'b1;
        cnt_val   = wash_t;        // shown during prep, not decremented
        prep_n    = PREP_LOAD;
        load_zero = PREP_ZERO;
      end else if (st == ST_WASH && prev_q == ST_PREP) begin
        do_load   = 1'b1;
        cnt_val   = wash_t;
        load_zero = (wash_t == '0);
      end else if (st == ST_DRY && prev_q == ST_WASH) begin
        do_load   = 1'b1;
        cnt_val   = dry_t;
        load_zero = (dry_t == '0);
      end else if ((st == ST_WASH && prev_q == ST_WASH_P) ||
                   (st == ST_DRY  && prev_q == ST_DRY_P)) begin
        // Resume: prescaler kept, entry cycle does not advance it
        run_n = !done_q;
      end else begin
        do_clear = 1'b1;
      end
    end else if (active && !done_q) begin
      run_n = 1'b1;
      if (ps_q == PS_LAST) begin
        tick = 1'b1;
        ps_n = '0;
      end else begin
        ps_n = ps_q + PS_W'(1);
      end
      if (tick) begin
        if (st == ST_PREP) begin
          if (prep_q != '0) begin
            prep_n = prep_q - PR_W'(1);
            if (prep_q == PR_W'(1)) begin
              done_n = 1'b1;
              co_n   = 1'b1;
              run_n  = 1'b0;
            end
          end
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
          if (cnt_is_one) begin
            done_n = 1'b1;
            co_n   = 1'b1;
            run_n  = 1'b0;
          end
        end
      end
    end

    // Zero-length loads expire immediately, without waiting for a tick
    if (do_load) begin
      cnt_load = 1'b1;
      ps_n     = '0;
      done_n   = load_zero;
      co_n     = load_zero;
      run_n    = !load_zero;
    end

    if (do_clear) begin
      prev_n   = ST_IDLE;
      ps_n     = '0;
      prep_n   = '0;
      done_n   = 1'b0;
      cnt_load = 1'b1;
      cnt_val  = '0;
      co_n     = 1'b0;
      run_n    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      ps_q   <= '0;
      prep_q <= '0;
      done_q <= 1'b0;
      co_q   <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      prev_q <= prev_n;
      ps_q   <= ps_n;
      prep_q <= prep_n;
      done_q <= done_n;
      co_q   <= co_n;
      run_q  <= run_n;
    end
  end

  assign bus.rem_hr      = cnt_q.hr;
  assign bus.rem_min_ten = cnt_q.min_ten;
  assign bus.rem_min_one = cnt_q.min_one;
  assign bus.complete_op = co_q;
  assign bus.running     = run_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Self-checking bench for wm_phase_timer: directed vector table, hand-written
// corner sequences, then randomized controller traffic against a minute-based
// reference model.
module tb_wm_phase_timer;
  import wm_pkg::*;

  localparam int unsigned TD = 4;
  localparam int unsigned PT = 3;
  localparam int NVEC = 19;

  logic clk = 1'b0;
  logic reset;

  wm_phase_timer_if bus();

  wm_phase_timer #(.TICK_DIV(TD), .PREP_TICKS(PT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  st;
    logic [11:0] wash;
    logic [11:0] dry;
    int          ncyc;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[NVEC];

  // Reference model: remaining time as plain minutes, tick as elapsed cycles
  int m_prev, m_mins, m_prep, m_elapsed;
  bit m_done, m_co, m_run;

  function automatic int lim(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int to_min(input logic [11:0] t);
    return lim(int'(t[11:8]), 9) * 60 + lim(int'(t[7:4]), 5) * 10 + lim(int'(t[3:0]), 9);
  endfunction

  function automatic logic [13:0] model_vec();
    int hr, ten, one;
    hr  = m_mins / 60;
    ten = (m_mins % 60) / 10;
    one = m_mins % 10;
    return {4'(hr), 4'(ten), 4'(one), m_co, m_run};
  endfunction

  task automatic model_clear();
    m_prev = 0; m_mins = 0; m_prep = 0; m_elapsed = 0;
    m_done = 0; m_co = 0; m_run = 0;
  endtask

  task automatic model_expire();
    m_done = 1; m_co = 1; m_run = 0;
  endtask

  task automatic model_edge(input logic rst, input int st,
                            input logic [11:0] wash, input logic [11:0] dry);
    bit ld, zero, act;
    ld = 0; zero = 0;
    act = (st == 1) || (st == 3) || (st == 5);
    m_co = 0; m_run = 0;
    if (rst || st == 0) begin
      model_clear();
      return;
    end
    if (st != m_prev) begin
      if (st == 5 && m_prev == 0) begin
        ld = 1; m_prep = PT; m_mins = to_min(wash); zero = (PT == 0);
      end else if (st == 1 && m_prev == 5) begin
        ld = 1; m_mins = to_min(wash); zero = (m_mins == 0);
      end else if (st == 3 && m_prev == 1) begin
        ld = 1; m_mins = to_min(dry); zero = (m_mins == 0);
      end else if ((st == 1 && m_prev == 2) || (st == 3 && m_prev == 4)) begin
        m_run = !m_done;
      end else if (act) begin
        model_clear();
        return;
      end
      m_prev = st;
      if (ld) begin
        m_elapsed = 0; m_done = zero; m_co = zero; m_run = !zero;
      end
    end else if (act && !m_done) begin
      m_run = 1;
      m_elapsed++;
      if (m_elapsed == TD) begin
        m_elapsed = 0;
        if (st == 5) begin
          if (m_prep > 0) begin
            m_prep--;
            if (m_prep == 0) model_expire();
          end
        end else if (m_mins > 0) begin
          m_mins--;
          if (m_mins == 0) model_expire();
        end
      end
    end
  endtask

  function automatic logic [13:0] dut_vec();
    return {bus.rem_hr, bus.rem_min_ten, bus.rem_min_one, bus.complete_op, bus.running};
  endfunction

  function automatic logic [13:0] ev(input logic [11:0] rem, input logic co, input logic run);
    return {rem, co, run};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [2:0] st, input logic [11:0] w,
                              input logic [11:0] d, input int n, input logic [11:0] rem,
                              input logic co, input logic run);
    vec_t v;
    v.rst = rst; v.st = st; v.wash = w; v.dry = d; v.ncyc = n; v.exp = ev(rem, co, run);
    return v;
  endfunction

  task automatic set_times(input logic [11:0] w, input logic [11:0] d);
    {bus.wash_hr, bus.wash_min_ten, bus.wash_min_one} = w;
    {bus.dry_hr, bus.dry_min_ten, bus.dry_min_one}    = d;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge(reset, int'(bus.state),
                 {bus.wash_hr, bus.wash_min_ten, bus.wash_min_one},
                 {bus.dry_hr, bus.dry_min_ten, bus.dry_min_one});
      #1;
    end
  endtask

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rem=%h co=%b run=%b, expected rem=%h co=%b run=%b",
               name, act[13:2], act[1], act[0], exp[13:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Enter a phase and wait (bounded) for its complete_op; n = -1 on timeout
  task automatic enter_wait(input logic [2:0] st, input int budget, output int n);
    bus.state = st;
    n = 0;
    while (n < budget) begin
      step(1);
      n++;
      if (bus.complete_op === 1'b1) return;
    end
    n = -1;
  endtask

  initial begin
    int n, pulses, r;
    logic [2:0] s;

    reset = 1'b1;
    bus.state = 3'd0;
    set_times(12'h002, 12'h001);
    model_clear();

    // Main flow: wash 0:02, dry 0:01, controller advances the cycle after each pulse
    vecs[0]  = mk(1, 3'd0, 12'h002, 12'h001, 1,  12'h000, 0, 0);
    vecs[1]  = mk(0, 3'd0, 12'h002, 12'h001, 2,  12'h000, 0, 0);
    vecs[2]  = mk(0, 3'd5, 12'h002, 12'h001, 1,  12'h002, 0, 1);
    vecs[3]  = mk(0, 3'd5, 12'h002, 12'h001, 11, 12'h002, 0, 1);
    vecs[4]  = mk(0, 3'd5, 12'h002, 12'h001, 1,  12'h002, 1, 0);
    vecs[5]  = mk(0, 3'd1, 12'h002, 12'h001, 1,  12'h002, 0, 1);
    vecs[6]  = mk(0, 3'd1, 12'h002, 12'h001, 3,  12'h002, 0, 1);
    vecs[7]  = mk(0, 3'd1, 12'h002, 12'h001, 1,  12'h001, 0, 1);
    vecs[8]  = mk(0, 3'd1, 12'h002, 12'h001, 3,  12'h001, 0, 1);
    vecs[9]  = mk(0, 3'd1, 12'h002, 12'h001, 1,  12'h000, 1, 0);
    vecs[10] = mk(0, 3'd3, 12'h002, 12'h001, 1,  12'h001, 0, 1);
    vecs[11] = mk(0, 3'd3, 12'h002, 12'h001, 3,  12'h001, 0, 1);
    vecs[12] = mk(0, 3'd3, 12'h002, 12'h001, 1,  12'h000, 1, 0);
    vecs[13] = mk(0, 3'd3, 12'h002, 12'h001, 2,  12'h000, 0, 0);
    vecs[14] = mk(0, 3'd0, 12'h002, 12'h001, 1,  12'h000, 0, 0);
    // Clamp on load, then reset during prep
    vecs[15] = mk(0, 3'd0, 12'hB7C, 12'h001, 1,  12'h000, 0, 0);
    vecs[16] = mk(0, 3'd5, 12'hB7C, 12'h001, 1,  12'h959, 0, 1);
    vecs[17] = mk(1, 3'd5, 12'hB7C, 12'h001, 1,  12'h000, 0, 0);
    vecs[18] = mk(0, 3'd0, 12'hB7C, 12'h001, 1,  12'h000, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      reset     = vecs[i].rst;
      bus.state = vecs[i].st;
      set_times(vecs[i].wash, vecs[i].dry);
      step(vecs[i].ncyc);
      check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
    end
    reset = 1'b0;

    // Wash 1:00: hour and tens borrows
    set_times(12'h100, 12'h001);
    bus.state = 3'd0; step(1);
    enter_wait(3'd5, 40, n);
    check_int("prep_len", n, 13);
    bus.state = 3'd1; step(1);
    check("hr_load", dut_vec(), ev(12'h100, 0, 1));
    step(4);
    check("hr_borrow", dut_vec(), ev(12'h059, 0, 1));
    step(36);
    check("min_050", dut_vec(), ev(12'h050, 0, 1));
    step(4);
    check("ten_borrow", dut_vec(), ev(12'h049, 0, 1));

    // Pause mid-wash with the prescaler at 1, hold 10 cycles, resume
    set_times(12'h005, 12'h001);
    bus.state = 3'd0; step(1);
    enter_wait(3'd5, 40, n);
    bus.state = 3'd1; step(2);
    bus.state = 3'd2;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("pause_hold%0d", i), dut_vec(), ev(12'h005, 0, 0));
    end
    bus.state = 3'd1; step(1);
    check("resume", dut_vec(), ev(12'h005, 0, 1));
    step(2);
    check("resume_pre_tick", dut_vec(), ev(12'h005, 0, 1));
    step(1);
    check("resume_tick", dut_vec(), ev(12'h004, 0, 1));

    // Zero-length wash: single immediate pulse
    set_times(12'h000, 12'h001);
    bus.state = 3'd0; step(1);
    enter_wait(3'd5, 40, n);
    bus.state = 3'd1; step(1);
    check("zero_load", dut_vec(), ev(12'h000, 1, 0));
    pulses = 1;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (bus.complete_op === 1'b1) pulses++;
    end
    check_int("zero_pulses", pulses, 1);

    // Abort mid-dry
    set_times(12'h001, 12'h003);
    bus.state = 3'd0; step(1);
    enter_wait(3'd5, 40, n);
    enter_wait(3'd1, 20, n);
    check_int("wash_len", n, 5);
    bus.state = 3'd3; step(5);
    check("dry_mid", dut_vec(), ev(12'h002, 0, 1));
    bus.state = 3'd0; step(1);
    check("dry_abort", dut_vec(), ev(12'h000, 0, 0));

    // Randomized controller traffic against the model
    for (int c = 0; c < 6000; c++) begin
      r = int'($urandom_range(0, 999));
      reset = (r < 4);
      s = bus.state;
      if (m_co && $urandom_range(0, 4) != 0) begin
        case (s)
          3'd5:    s = 3'd1;
          3'd1:    s = 3'd3;
          3'd3:    s = 3'd0;
          default: s = s;
        endcase
      end else if (r < 30) begin
        s = 3'($urandom_range(0, 7));
      end else if (r < 80) begin
        case (s)
          3'd1:    s = 3'd2;
          3'd2:    s = 3'd1;
          3'd3:    s = 3'd4;
          3'd4:    s = 3'd3;
          default: s = s;
        endcase
      end else if (r < 90) begin
        s = 3'd0;
      end else if (s == 3'd0 && r < 400) begin
        s = 3'd5;
      end
      if ($urandom_range(0, 19) == 0) begin
        set_times({4'($urandom_range(0, 9) == 0), 4'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15))},
                  {4'(0), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 15))});
      end
      bus.state = s;
      step(1);
      check($sformatf("rand%0d", c), dut_vec(), model_vec());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
